// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the RISC-V opcode constants seen by the ID stage, the NOP word
// (addi x0,x0,0) used to fill an empty or flushed IF/ID register, and the
// fetch FSM state encoding.
package busca_instrucao_pkg;

    localparam logic [6:0]  OP_TIPO_I = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        INICIO    = 2'd0,  // first cycle after reset, no request yet
        BUSCA     = 2'd1,  // request outstanding
        ESPERA_ID = 2'd2,  // skid buffer full, request dropped
        DESCARTE  = 2'd3   // waiting out a stale request after a redirect
    } estado_t;

    // Forces a byte address onto a word boundary.
    function automatic logic [31:0] alinha_palavra(input logic [31:0] endereco);
        return {endereco[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction memory port of the fetch stage.
//   imem_req   : fetch request valid (driven by the fetch stage)
//   imem_addr  : word-aligned fetch address
//   imem_ready : imem_rdata is valid this cycle
//   imem_rdata : fetched instruction word
// Handshake: a transfer completes on a rising clk edge where imem_req and
// imem_ready are both 1. Once imem_req is raised, imem_req and imem_addr stay
// unchanged until that edge; memory only asserts imem_ready while imem_req is
// high and must tolerate a request abandoned by reset.
interface busca_instrucao_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/busca_instrucao_reg_if_id.sv
// IF/ID pipeline register with a one-entry skid buffer.
//   clk, reset          : clock, asynchronous active-high reset
//   stall_i             : ID cannot accept the current IF/ID contents
//   flush_i             : squash IF/ID and skid (taken branch)
//   carrega_i           : load {dado_i, pc_i} into IF/ID (caller ensures IF/ID is free)
//   grava_skid_i        : park {dado_i, pc_i} in the skid buffer
//   skid_para_if_id_i   : move the skid entry into IF/ID and empty the skid
//   dado_i, pc_i        : fetched word and its PC
//   valid_o, instrucao_o, pc_o : IF/ID contents
//   skid_cheio_o        : skid buffer holds an entry
module busca_instrucao_reg_if_id
    import busca_instrucao_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        carrega_i,
    input  logic        grava_skid_i,
    input  logic        skid_para_if_id_i,
    input  logic [31:0] dado_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instrucao_o,
    output logic [31:0] pc_o,
    output logic        skid_cheio_o
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        livre;

    // ID takes the current entry on any edge where it is empty or not stalled.
    assign livre = !valid_q || !stall_i;

    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush_i) begin
            valid_d      = 1'b0;
            instr_d      = NOP;
            skid_valid_d = 1'b0;
        end else begin
            if (grava_skid_i) begin
                skid_valid_d = 1'b1;
                skid_instr_d = dado_i;
                skid_pc_d    = pc_i;
            end
            if (skid_para_if_id_i) begin
                valid_d      = 1'b1;
                instr_d      = skid_instr_q;
                pc_d         = skid_pc_q;
                skid_valid_d = 1'b0;
            end else if (carrega_i) begin
                valid_d = 1'b1;
                instr_d = dado_i;
                pc_d    = pc_i;
            end else if (livre) begin
                // Entry consumed with nothing to replace it: insert a bubble
                // so ID never sees the same instruction twice. PC is kept.
                valid_d = 1'b0;
                instr_d = NOP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            instr_q      <= NOP;
            pc_q         <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP;
            skid_pc_q    <= 32'h0;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign valid_o      = valid_q;
    assign instrucao_o  = instr_q;
    assign pc_o         = pc_q;
    assign skid_cheio_o = skid_valid_q;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage with IF/ID register.
//   clk, reset        : clock, asynchronous active-high reset
//   imem              : instruction memory port (master side)
//   stall             : ID cannot accept, IF/ID holds
//   desvio_tomado     : taken branch resolved downstream, redirect + flush
//   desvio_pc         : PC of that branch
//   desvio_imm        : sign-extended B-type immediate
//   if_id_valid, if_id_instrucao, if_id_opcode, if_id_pc : IF/ID contents to ID
//   erro_alinhamento  : one-cycle pulse, redirect target was not word aligned
//   estado_dbg        : current fetch FSM state
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    reset,
    busca_instrucao_if.master       imem,
    input  logic                    stall,
    input  logic                    desvio_tomado,
    input  logic [31:0]             desvio_pc,
    input  logic [31:0]             desvio_imm,
    output logic                    if_id_valid,
    output logic [31:0]             if_id_instrucao,
    output logic [6:0]              if_id_opcode,
    output logic [31:0]             if_id_pc,
    output logic                    erro_alinhamento,
    output estado_t                 estado_dbg
);

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        erro_q, erro_d;

    logic [31:0] alvo;
    logic [31:0] alvo_alinhado;
    logic [31:0] pc_mais4;
    logic        if_id_livre;
    logic        carrega;
    logic        grava_skid;
    logic        skid_para_if_id;
    logic        flush;
    logic        skid_cheio;

    assign alvo          = desvio_pc + desvio_imm;
    assign alvo_alinhado = alinha_palavra(alvo);
    assign pc_mais4      = pc_q + 32'd4;   // wraps silently at 2^32
    assign if_id_livre   = !if_id_valid || !stall;

    always_comb begin
        estado_d        = estado_q;
        pc_d            = pc_q;
        req_d           = req_q;
        addr_d          = addr_q;
        erro_d          = 1'b0;
        carrega         = 1'b0;
        grava_skid      = 1'b0;
        skid_para_if_id = 1'b0;
        flush           = 1'b0;

        if (desvio_tomado) begin
            // Redirect outranks stall and any response arriving this cycle.
            flush  = 1'b1;
            pc_d   = alvo_alinhado;
            erro_d = (alvo[1:0] != 2'b00);
            if (!req_q || imem.imem_ready) begin
                req_d    = 1'b1;
                addr_d   = alvo_alinhado;
                estado_d = BUSCA;
            end else begin
                // Request still in flight: address must stay put until it
                // completes, so wait it out and drop the returned word.
                estado_d = DESCARTE;
            end
        end else begin
            unique case (estado_q)
                INICIO: begin
                    req_d    = 1'b1;
                    addr_d   = pc_q;
                    estado_d = BUSCA;
                end
                BUSCA: begin
                    if (imem.imem_ready) begin
                        pc_d = pc_mais4;
                        if (if_id_livre) begin
                            carrega = 1'b1;
                            addr_d  = pc_mais4;
                        end else begin
                            grava_skid = 1'b1;
                            req_d      = 1'b0;
                            estado_d   = ESPERA_ID;
                        end
                    end
                end
                ESPERA_ID: begin
                    if (!stall) begin
                        skid_para_if_id = 1'b1;
                        req_d           = 1'b1;
                        addr_d          = pc_q;
                        estado_d        = BUSCA;
                    end
                end
                DESCARTE: begin
                    if (imem.imem_ready) begin
                        req_d    = 1'b1;
                        addr_d   = pc_q;
                        estado_d = BUSCA;
                    end
                end
                default: estado_d = INICIO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= INICIO;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            erro_q   <= erro_d;
        end
    end

    busca_instrucao_reg_if_id #(
        .NOP (NOP)
    ) u_reg_if_id (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall),
        .flush_i           (flush),
        .carrega_i         (carrega),
        .grava_skid_i      (grava_skid),
        .skid_para_if_id_i (skid_para_if_id),
        .dado_i            (imem.imem_rdata),
        .pc_i              (pc_q),
        .valid_o           (if_id_valid),
        .instrucao_o       (if_id_instrucao),
        .pc_o              (if_id_pc),
        .skid_cheio_o      (skid_cheio)
    );

    assign imem.imem_req   = req_q;
    assign imem.imem_addr  = addr_q;
    assign if_id_opcode    = if_id_instrucao[6:0];
    assign erro_alinhamento = erro_q;
    assign estado_dbg      = estado_q;

    // Skid occupancy is fully implied by ESPERA_ID; kept visible for debug.
    logic skid_cheio_nao_usado;
    assign skid_cheio_nao_usado = skid_cheio;

endmodule

// File: tb/tb_busca_instrucao.sv
module tb_busca_instrucao;
    import busca_instrucao_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        desvio_tomado;
    logic [31:0] desvio_pc;
    logic [31:0] desvio_imm;
    logic        if_id_valid;
    logic [31:0] if_id_instrucao;
    logic [6:0]  if_id_opcode;
    logic [31:0] if_id_pc;
    logic        erro_alinhamento;
    estado_t     estado_dbg;

    busca_instrucao_if mem_if ();

    busca_instrucao #(
        .RESET_PC (32'h0000_0000),
        .NOP      (32'h0000_0013)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem             (mem_if),
        .stall            (stall),
        .desvio_tomado    (desvio_tomado),
        .desvio_pc        (desvio_pc),
        .desvio_imm       (desvio_imm),
        .if_id_valid      (if_id_valid),
        .if_id_instrucao  (if_id_instrucao),
        .if_id_opcode     (if_id_opcode),
        .if_id_pc         (if_id_pc),
        .erro_alinhamento (erro_alinhamento),
        .estado_dbg       (estado_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- random-phase model state ----------------
    logic [31:0] exp_q[$];      // program-order PCs ID should receive next
    logic [31:0] exp_pc;
    logic [31:0] alvo;
    logic        exp_erro;
    logic        consumido;
    logic        segura;
    logic        pendente;
    logic        houve_desvio;
    logic [31:0] snap_instr;
    logic [31:0] snap_pc;
    logic [31:0] addr_ant;
    int          entregas;

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        desvio_tomado = 1'b0;
        desvio_pc     = 32'h0;
        desvio_imm    = 32'h0;
        mem_if.imem_ready = 1'b0;
        mem_if.imem_rdata = 32'h0;

        // ---- reset state ----
        repeat (2) tick();
        chk("rst_req",    32'(mem_if.imem_req), 32'h0);
        chk("rst_addr",   mem_if.imem_addr, 32'h0);
        chk("rst_valid",  32'(if_id_valid), 32'h0);
        chk("rst_instr",  if_id_instrucao, NOP_W);
        chk("rst_opcode", 32'(if_id_opcode), 32'h13);
        chk("rst_pc",     if_id_pc, 32'h0);
        chk("rst_erro",   32'(erro_alinhamento), 32'h0);
        chk("rst_estado", 32'(estado_dbg), 32'(INICIO));

        // ---- back-to-back fetch ----
        reset = 1'b0;
        tick();
        chk("b2b_req0",  32'(mem_if.imem_req), 32'h1);
        chk("b2b_addr0", mem_if.imem_addr, 32'h0);
        mem_if.imem_ready = 1'b1;
        mem_if.imem_rdata = 32'h0050_0093;
        tick();
        chk("b2b_valid1", 32'(if_id_valid), 32'h1);
        chk("b2b_instr1", if_id_instrucao, 32'h0050_0093);
        chk("b2b_op1",    32'(if_id_opcode), 32'h13);
        chk("b2b_pc1",    if_id_pc, 32'h0);
        chk("b2b_addr1",  mem_if.imem_addr, 32'h4);
        mem_if.imem_rdata = 32'h0020_9663;
        tick();
        chk("b2b_instr2", if_id_instrucao, 32'h0020_9663);
        chk("b2b_op2",    32'(if_id_opcode), 32'h63);
        chk("b2b_pc2",    if_id_pc, 32'h4);
        chk("b2b_addr2",  mem_if.imem_addr, 32'h8);

        // ---- memory ready every third cycle ----
        exp_pc = 32'h8;
        for (int k = 0; k < 3; k++) begin
            mem_if.imem_ready = 1'b0;
            for (int w = 0; w < 2; w++) begin
                tick();
                chk("slow_addr_hold", mem_if.imem_addr, exp_pc);
                chk("slow_req_hold",  32'(mem_if.imem_req), 32'h1);
                chk("slow_bubble",    32'(if_id_valid), 32'h0);
            end
            mem_if.imem_ready = 1'b1;
            mem_if.imem_rdata = mem_word(exp_pc);
            tick();
            chk("slow_valid", 32'(if_id_valid), 32'h1);
            chk("slow_pc",    if_id_pc, exp_pc);
            chk("slow_instr", if_id_instrucao, mem_word(exp_pc));
            chk("slow_next",  mem_if.imem_addr, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end

        // ---- stall while a response arrives: goes to skid ----
        mem_if.imem_ready = 1'b1;
        mem_if.imem_rdata = mem_word(32'h14);
        stall = 1'b1;
        tick();
        chk("stall_req",    32'(mem_if.imem_req), 32'h0);
        chk("stall_valid",  32'(if_id_valid), 32'h1);
        chk("stall_pc",     if_id_pc, 32'h10);
        chk("stall_instr",  if_id_instrucao, mem_word(32'h10));
        chk("stall_estado", 32'(estado_dbg), 32'(ESPERA_ID));
        mem_if.imem_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_hold_req",   32'(mem_if.imem_req), 32'h0);
            chk("stall_hold_pc",    if_id_pc, 32'h10);
            chk("stall_hold_instr", if_id_instrucao, mem_word(32'h10));
        end
        stall = 1'b0;
        tick();
        chk("skid_valid", 32'(if_id_valid), 32'h1);
        chk("skid_pc",    if_id_pc, 32'h14);
        chk("skid_instr", if_id_instrucao, mem_word(32'h14));
        chk("skid_req",   32'(mem_if.imem_req), 32'h1);
        chk("skid_addr",  mem_if.imem_addr, 32'h18);
        mem_if.imem_ready = 1'b1;
        mem_if.imem_rdata = mem_word(32'h18);
        tick();
        chk("resume_pc",   if_id_pc, 32'h18);
        chk("resume_addr", mem_if.imem_addr, 32'h1C);

        // ---- redirect with ready and stall in the same cycle ----
        stall = 1'b1;
        mem_if.imem_rdata = mem_word(32'h1C);
        desvio_tomado = 1'b1;
        desvio_pc  = 32'h40;
        desvio_imm = 32'hFFFF_FFF8;
        tick();
        chk("rdir_valid", 32'(if_id_valid), 32'h0);
        chk("rdir_instr", if_id_instrucao, NOP_W);
        chk("rdir_req",   32'(mem_if.imem_req), 32'h1);
        chk("rdir_addr",  mem_if.imem_addr, 32'h38);
        chk("rdir_erro",  32'(erro_alinhamento), 32'h0);
        desvio_tomado = 1'b0;
        stall = 1'b0;
        mem_if.imem_rdata = mem_word(32'h38);
        tick();
        chk("rdir_pc",    if_id_pc, 32'h38);
        chk("rdir_word",  if_id_instrucao, mem_word(32'h38));
        chk("rdir_next",  mem_if.imem_addr, 32'h3C);

        // ---- redirect while a request is pending ----
        mem_if.imem_ready = 1'b0;
        desvio_tomado = 1'b1;
        desvio_pc  = 32'h80;
        desvio_imm = 32'h80;
        tick();
        chk("desc_addr",   mem_if.imem_addr, 32'h3C);
        chk("desc_req",    32'(mem_if.imem_req), 32'h1);
        chk("desc_valid",  32'(if_id_valid), 32'h0);
        chk("desc_estado", 32'(estado_dbg), 32'(DESCARTE));
        desvio_tomado = 1'b0;
        tick();
        chk("desc_addr_hold", mem_if.imem_addr, 32'h3C);
        mem_if.imem_ready = 1'b1;
        mem_if.imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("desc_drop",   32'(if_id_valid), 32'h0);
        chk("desc_target", mem_if.imem_addr, 32'h100);
        mem_if.imem_rdata = mem_word(32'h100);
        tick();
        chk("desc_pc",    if_id_pc, 32'h100);
        chk("desc_word",  if_id_instrucao, mem_word(32'h100));

        // ---- misaligned target ----
        mem_if.imem_rdata = 32'hDEAD_BEEF;
        desvio_tomado = 1'b1;
        desvio_pc  = 32'h10;
        desvio_imm = 32'h6;
        tick();
        chk("mis_erro",  32'(erro_alinhamento), 32'h1);
        chk("mis_addr",  mem_if.imem_addr, 32'h14);
        chk("mis_valid", 32'(if_id_valid), 32'h0);
        desvio_tomado = 1'b0;
        mem_if.imem_ready = 1'b0;
        tick();
        chk("mis_pulse", 32'(erro_alinhamento), 32'h0);
        chk("mis_hold",  mem_if.imem_addr, 32'h14);

        // ---- PC wrap ----
        mem_if.imem_ready = 1'b1;
        desvio_tomado = 1'b1;
        desvio_pc  = 32'hFFFF_FFF0;
        desvio_imm = 32'hC;
        tick();
        chk("wrap_addr", mem_if.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_erro", 32'(erro_alinhamento), 32'h0);
        desvio_tomado = 1'b0;
        mem_if.imem_rdata = mem_word(32'hFFFF_FFFC);
        tick();
        chk("wrap_pc",   if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_next", mem_if.imem_addr, 32'h0);
        mem_if.imem_rdata = mem_word(32'h0);
        tick();
        chk("wrap_pc0",  if_id_pc, 32'h0);
        chk("wrap_addr4", mem_if.imem_addr, 32'h4);

        // ---- reset mid-transaction ----
        mem_if.imem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req",   32'(mem_if.imem_req), 32'h0);
        chk("arst_addr",  mem_if.imem_addr, 32'h0);
        chk("arst_valid", 32'(if_id_valid), 32'h0);
        chk("arst_instr", if_id_instrucao, NOP_W);
        tick();
        reset = 1'b0;

        // ---- randomized run against a program-order model ----
        // The model only knows: instructions reach ID in address order,
        // each word equals mem_word(pc), and a taken branch restarts the
        // order at the aligned target.
        exp_q.delete();
        exp_q.push_back(32'h0);
        entregas = 0;
        for (int c = 0; c < 3000; c++) begin
            stall         = ($urandom_range(0, 3) == 0);
            desvio_tomado = ($urandom_range(0, 19) == 0);
            desvio_pc     = $urandom;
            desvio_imm    = $urandom & 32'hFFFF_FFFE;
            mem_if.imem_ready = mem_if.imem_req && ($urandom_range(0, 2) != 0);
            mem_if.imem_rdata = mem_if.imem_ready ? mem_word(mem_if.imem_addr) : $urandom;

            consumido    = if_id_valid && !stall && !desvio_tomado;
            segura       = if_id_valid && stall && !desvio_tomado;
            pendente     = mem_if.imem_req && !mem_if.imem_ready;
            houve_desvio = desvio_tomado;
            addr_ant     = mem_if.imem_addr;
            snap_instr   = if_id_instrucao;
            snap_pc      = if_id_pc;

            if (consumido) begin
                exp_pc = exp_q.pop_front();
                chk("rnd_pc",    if_id_pc, exp_pc);
                chk("rnd_instr", if_id_instrucao, mem_word(exp_pc));
                exp_q.push_back(exp_pc + 32'd4);
                entregas++;
            end
            if (desvio_tomado) begin
                alvo = desvio_pc + desvio_imm;
                exp_q.delete();
                exp_q.push_back({alvo[31:2], 2'b00});
                exp_erro = (alvo[1:0] != 2'b00);
            end else begin
                exp_erro = 1'b0;
            end

            tick();

            chk("rnd_erro", 32'(erro_alinhamento), 32'(exp_erro));
            if (houve_desvio)
                chk("rnd_flush", 32'(if_id_valid), 32'h0);
            if (segura) begin
                chk("rnd_hold_valid", 32'(if_id_valid), 32'h1);
                chk("rnd_hold_instr", if_id_instrucao, snap_instr);
                chk("rnd_hold_pc",    if_id_pc, snap_pc);
            end
            if (pendente) begin
                chk("rnd_req_hold",  32'(mem_if.imem_req), 32'h1);
                chk("rnd_addr_hold", mem_if.imem_addr, addr_ant);
            end
            if (mem_if.imem_req)
                chk("rnd_addr_align", 32'(mem_if.imem_addr[1:0]), 32'h0);
            if (!if_id_valid)
                chk("rnd_empty_nop", if_id_instrucao, NOP_W);
        end
        chk("rnd_progress", 32'(entregas >= 300), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction fetch stage with its IF/ID pipeline register, directly upstream of the immediate generator and decoder. It holds the PC and fetches words from instruction memory over a req/ready handshake. It presents the fetched instruction, its opcode field and its PC to the ID stage, where the immediate generator and decoder consume them. Stall and branch-redirect inputs come from later stages; the redirect target is computed here from the branch PC plus the sign-extended B-type immediate.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP, 32'h0000_0013, instruction word (addi x0,x0,0) placed in IF/ID when empty or flushed.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch address, word aligned.
imem_ready  in  1  imem_rdata is valid this cycle; completes the request.
imem_rdata  in  32  fetched instruction word.
stall  in  1  ID cannot accept; IF/ID must hold.
desvio_tomado  in  1  taken branch (BNE) resolved downstream; redirect and flush.
desvio_pc  in  32  PC of the branch instruction.
desvio_imm  in  32  sign-extended B immediate (bit0 = 0) from the immediate generator.
if_id_valid  out  1  IF/ID holds a live instruction.
if_id_instrucao  out  32  instruction word to ID and the immediate generator.
if_id_opcode  out  7  equals if_id_instrucao[6:0].
if_id_pc  out  32  PC of if_id_instrucao.
erro_alinhamento  out  1  one-cycle pulse: redirect target had bits[1:0] != 0.

Behaviour:
- Reset is asynchronous, active-high, on a single clock clk. Reset values: pc=RESET_PC, state=INICIO, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instrucao=NOP, if_id_opcode=7'b0010011, if_id_pc=0, erro_alinhamento=0, skid buffer empty.
- imem_req and imem_addr are registered. Once imem_req is raised, addr stays stable until the cycle imem_ready=1.
- FSM states:
  - INICIO: first clock after reset deassert -> BUSCA with imem_req=1 and imem_addr=pc.
  - BUSCA (request outstanding):
    - On imem_ready with IF/ID free (!if_id_valid or !stall): load IF/ID with {rdata, pc}, valid=1, pc<=pc+4, and keep requesting at the new pc. Back-to-back throughput is 1 instruction/cycle when memory is ready every cycle.
    - On imem_ready with stall=1 and if_id_valid=1: write {rdata, pc} into the one-entry skid buffer, pc<=pc+4, imem_req<=0 -> ESPERA_ID.
  - ESPERA_ID (skid full, no request): when stall=0, move skid to IF/ID, empty the skid, reassert imem_req at pc -> BUSCA.
  - DESCARTE: entered on redirect while a request is outstanding and imem_ready=0. Keep the old req/addr until imem_ready, discard that rdata, then request the target -> BUSCA.
- Redirect (desvio_tomado=1) has priority over stall and over any memory response in the same cycle:
  - alvo = desvio_pc + desvio_imm, modulo 2^32.
  - pc <= {alvo[31:2], 2'b00}. If alvo[1:0] != 0, pulse erro_alinhamento.
  - IF/ID <= {NOP, valid=0}; skid emptied.
  - If imem_ready=1 in the same cycle or no request is outstanding, the next cycle requests the target (BUSCA). Otherwise go to DESCARTE.
- stall=1 with if_id_valid=0 does not block: IF/ID loads normally.
- With stall=1 and if_id_valid=1, IF/ID contents are bit-stable.
- pc+4 wraps from 32'hFFFF_FFFC to 0 without any flag.
- Reset asserted mid-transaction abandons the request immediately (imem_req=0 asynchronously). Memory must tolerate an abandoned request.

Decomposition:
- Shared package holds: opcode constants (OP_TIPO_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011), the NOP constant, and the FSM state encoding (INICIO, BUSCA, ESPERA_ID, DESCARTE).
- One natural sub-module: reg_if_id, the IF/ID register plus skid buffer with load/hold/flush controls. The fetch FSM and PC logic stay in the top module.

Test Plan:
- Reset release, imem_ready=1 every cycle with words 0x00500093, 0x00209663 -> addr sequence 0,4,8; IF/ID shows {0x00500093, pc 0}, then {0x00209663, pc 4}; opcodes 0x13 then 0x63.
- Memory ready every 3rd cycle -> imem_addr held stable while waiting; one IF/ID load per response; no duplicated or skipped PCs.
- stall=1 for 4 cycles while a response arrives -> IF/ID unchanged, response goes to skid, imem_req=0. On stall release, the skid word appears next cycle with the correct pc and fetching resumes at pc+4.
- desvio_tomado with desvio_pc=0x40, desvio_imm=0xFFFFFFF8 in the same cycle as imem_ready and stall=1 -> if_id_valid=0 with NOP; the response is dropped; the next request is to 0x38.
- Redirect while a request is pending (ready=0), target 0x100 -> addr stays at the old value until ready; that rdata is discarded; then a request to 0x100.
- desvio_pc=0x10, desvio_imm=0x6 -> erro_alinhamento pulses 1 cycle; fetch goes to 0x14. Separately, start at PC 0xFFFF_FFFC -> the next fetch is at 0x0.
